// File: rtl/mem_access_stage_pkg.sv
// rv_mem_pkg: shared types and constants for the memory-access stage.
//   F3_*         RV32I load/store funct3 encodings
//   mem_state_t  stage FSM states (IDLE, BUSY, DONE)
//   WSTRB_W      byte-enable width of the data-memory bus
package rv_mem_pkg;

   localparam int unsigned WSTRB_W = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus.
//   req    request valid (held until ack or timeout)
//   we     1 = write
//   addr   word-aligned byte address
//   wdata  lane-replicated store data
//   wstrb  byte enables (0 on loads)
//   rdata  read data, valid with ack
//   ack    one-cycle completion
// Modports: master = memory-access stage, slave = memory.
interface mem_access_stage_if
   import rv_mem_pkg::*;
#(
   parameter int unsigned XLEN = 32
) ();

   logic               req;
   logic               we;
   logic [XLEN-1:0]    addr;
   logic [XLEN-1:0]    wdata;
   logic [WSTRB_W-1:0] wstrb;
   logic [XLEN-1:0]    rdata;
   logic               ack;

   modport master (
      output req, we, addr, wdata, wstrb,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata, wstrb,
      output rdata, ack
   );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load-data formatter.
//   i_rdata   raw word from memory
//   i_a       byte offset of the access within the word
//   i_funct3  load encoding (LB/LH/LBU/LHU sign/zero-extend, others full word)
//   o_data    extended result
// Halves take the lane from i_a[1]; i_a[0] is ignored for them.
module load_align
   import rv_mem_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_a,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[{i_a, 3'b000} +: 8];
      w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline M stage. Turns a load/store into one req/ack bus
// transaction, stalls the pipeline until it completes and formats load data.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   MemReadM, MemWriteM   load / store in M (both high = load)
//   funct3M               access size/sign
//   ALUResultM            effective byte address
//   WriteDataM            store data (rs2)
//   ReadDataM             formatted load result, registered, valid in DONE
//   StallM                freeze IF..M while high
//   BusErrM               one-cycle pulse in DONE on ack timeout
//   MisalignM             one-cycle pulse in DONE on misaligned access
//   dmem                  data-memory bus (master side)
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halves/words
// without issuing a bus request; otherwise MisalignM is tied low.
module mem_access_stage
   import rv_mem_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               MemReadM,
   input  logic               MemWriteM,
   input  logic [2:0]         funct3M,
   input  logic [XLEN-1:0]    ALUResultM,
   input  logic [XLEN-1:0]    WriteDataM,
   output logic [XLEN-1:0]    ReadDataM,
   output logic               StallM,
   output logic               BusErrM,
   output logic               MisalignM,
   mem_access_stage_if.master dmem
);

   localparam logic [7:0] CntLast = 8'(MAX_WAIT - 1);

   mem_state_t         r_state, w_state_d;
   logic [7:0]         r_cnt;
   logic               r_req, r_we, r_buserr;
   logic [WSTRB_W-1:0] r_wstrb;
   logic [XLEN-1:0]    r_addr, r_wdata, r_rdata;
   logic [2:0]         r_f3;
   logic [1:0]         r_a;

   logic               w_access, w_misalign;
   logic               w_issue, w_trap, w_ack_take, w_timeout;
   logic [WSTRB_W-1:0] w_wstrb;
   logic [XLEN-1:0]    w_wdata, w_load_data;

   assign w_access = MemReadM | MemWriteM;

   // Store lane generation from the live address.
   always_comb begin
      case (funct3M)
         F3_SB: begin
            w_wstrb = 4'b0001 << ALUResultM[1:0];
            w_wdata = {(XLEN/8){WriteDataM[7:0]}};
         end
         F3_SH: begin
            w_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
            w_wdata = {(XLEN/16){WriteDataM[15:0]}};
         end
         default: begin
            w_wstrb = 4'hF;
            w_wdata = WriteDataM;
         end
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic r_mis;

   assign w_misalign = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                       ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_mis <= 1'b0;
      else       r_mis <= w_trap;
   end

   assign MisalignM = r_mis;
`else
   assign w_misalign = 1'b0;
   assign MisalignM  = 1'b0;
`endif

   // FSM next state and stall.
   always_comb begin
      w_state_d  = r_state;
      StallM     = 1'b0;
      w_issue    = 1'b0;
      w_trap     = 1'b0;
      w_ack_take = 1'b0;
      w_timeout  = 1'b0;
      unique case (r_state)
         IDLE: begin
            StallM = w_access;
            if (w_access) begin
               if (w_misalign) begin
                  w_trap    = 1'b1;
                  w_state_d = DONE;
               end else begin
                  w_issue   = 1'b1;
                  w_state_d = BUSY;
               end
            end
         end
         BUSY: begin
            StallM = 1'b1;
            // An ack on the timeout cycle takes priority over the error.
            if (dmem.ack) begin
               w_ack_take = 1'b1;
               w_state_d  = DONE;
            end else if (r_cnt == CntLast) begin
               w_timeout = 1'b1;
               w_state_d = DONE;
            end
         end
         DONE: begin
            // One free cycle so the retiring instruction leaves M.
            w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_d;
   end

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .i_rdata  (dmem.rdata),
      .i_a      (r_a),
      .i_funct3 (r_f3),
      .o_data   (w_load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_wstrb  <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_f3     <= '0;
         r_a      <= '0;
         r_cnt    <= '0;
         r_rdata  <= '0;
         r_buserr <= 1'b0;
      end else begin
         r_buserr <= w_timeout;
         if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= MemWriteM & ~MemReadM;
            r_wstrb <= MemReadM ? '0 : w_wstrb;
            r_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_f3    <= funct3M;
            r_a     <= ALUResultM[1:0];
            r_cnt   <= '0;
         end
         if (w_ack_take || w_timeout) begin
            r_req <= 1'b0;
            r_cnt <= '0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_ack_take && !r_we) r_rdata <= w_load_data;
         if (w_timeout || w_trap) r_rdata <= '0;
      end
   end

   assign ReadDataM  = r_rdata;
   assign BusErrM    = r_buserr;
   assign dmem.req   = r_req;
   assign dmem.we    = r_we;
   assign dmem.addr  = r_addr;
   assign dmem.wdata = r_wdata;
   assign dmem.wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases with literal expectations plus
// randomized loads/stores checked every cycle against a transaction-level model.
module tb_mem_access_stage;
   import rv_mem_pkg::*;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned MAX_WAIT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM, ReadDataM;
   logic        StallM, BusErrM, MisalignM;

   mem_access_stage_if #(.XLEN(XLEN)) dmem ();

   mem_access_stage #(
      .XLEN     (XLEN),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .BusErrM    (BusErrM),
      .MisalignM  (MisalignM),
      .dmem       (dmem)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected per-cycle outputs, set by the driver, checked at negedge.
   bit          e_valid = 0;
   logic        e_stall, e_req, e_err, e_mis, e_we;
   logic [31:0] e_rd = '0, e_addr, e_wdata;
   logic [3:0]  e_wstrb;
   logic [31:0] m_rd = '0;

   int          stall_cnt, req_cnt, err_cnt, mis_cnt;
   logic [3:0]  seen_wstrb;
   logic [31:0] seen_wdata;
   logic        seen_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---- behavioural model helpers ----
   function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] a);
      int sh;
      sh = int'(a);
      if (f3 == 3'd0) return 4'(1 << sh);
      if (f3 == 3'd1) return (sh >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] r);
      logic [31:0] b, h;
      int sh;
      sh = int'(a);
      b  = (r >> (8 * sh)) & 32'hFF;
      h  = (r >> (16 * (sh / 2))) & 32'hFFFF;
      case (f3)
         3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd4: return b;
         3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd5: return h;
         default: return r;
      endcase
   endfunction

   function automatic bit m_misal(input logic [2:0] f3, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01 && a[0]) return 1;
      if (f3[1:0] == 2'b10 && a != 2'b00) return 1;
`endif
      return 0;
   endfunction

   // ---- per-cycle compare process ----
   always @(negedge clk) begin
      if (e_valid) begin
         check("StallM", 32'(StallM), 32'(e_stall));
         check("dmem_req", 32'(dmem.req), 32'(e_req));
         check("BusErrM", 32'(BusErrM), 32'(e_err));
         check("MisalignM", 32'(MisalignM), 32'(e_mis));
         check("ReadDataM", ReadDataM, e_rd);
         if (e_req) begin
            check("dmem_addr", dmem.addr, e_addr);
            check("dmem_we", 32'(dmem.we), 32'(e_we));
            check("dmem_wstrb", 32'(dmem.wstrb), 32'(e_wstrb));
            if (e_we) check("dmem_wdata", dmem.wdata, e_wdata);
         end
         if (StallM)    stall_cnt++;
         if (dmem.req)  req_cnt++;
         if (BusErrM)   err_cnt++;
         if (MisalignM) mis_cnt++;
         if (dmem.req) begin
            seen_wstrb = dmem.wstrb;
            seen_wdata = dmem.wdata;
            seen_we    = dmem.we;
         end
      end
   end

   task automatic clr_counts();
      stall_cnt = 0; req_cnt = 0; err_cnt = 0; mis_cnt = 0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      funct3M    = 3'($urandom_range(0, 7));
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      dmem.ack   = 1'($urandom_range(0, 1));  // stray acks must be ignored
      dmem.rdata = $urandom;
      e_stall = 0; e_req = 0; e_err = 0; e_mis = 0; e_rd = m_rd;
   endtask

   // One instruction in M. delay = BUSY cycle index of the ack; >= MAX_WAIT means none.
   task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rdata);
      logic [1:0] a;
      bit         tmo;
      int         n_busy;
      a = addr[1:0];
      @(posedge clk); #1;
      MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      dmem.ack = 1'b0;
      e_stall = 1; e_req = 0; e_err = 0; e_mis = 0; e_rd = m_rd;
      if (m_misal(f3, a)) begin
         @(posedge clk); #1;
         m_rd = '0;
         e_stall = 0; e_mis = 1; e_rd = m_rd;
      end else begin
         tmo    = (delay >= int'(MAX_WAIT));
         n_busy = tmo ? int'(MAX_WAIT) : delay + 1;
         e_addr  = addr & 32'hFFFF_FFFC;
         e_we    = wr && !rd;
         e_wstrb = rd ? 4'h0 : m_wstrb(f3, a);
         e_wdata = m_wdata(f3, wd);
         for (int k = 0; k < n_busy; k++) begin
            @(posedge clk); #1;
            e_stall = 1; e_req = 1;
            dmem.ack   = (k == delay);
            dmem.rdata = (k == delay) ? rdata : $urandom;
         end
         @(posedge clk); #1;
         dmem.ack   = 1'($urandom_range(0, 1));
         dmem.rdata = $urandom;
         if (tmo)     m_rd = '0;
         else if (rd) m_rd = m_load(f3, a, rdata);
         e_stall = 0; e_req = 0; e_err = tmo; e_rd = m_rd;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
      dmem.ack = 0; dmem.rdata = 0;
      #12;
      check("rst_req", 32'(dmem.req), 32'd0);
      check("rst_we", 32'(dmem.we), 32'd0);
      check("rst_wstrb", 32'(dmem.wstrb), 32'd0);
      check("rst_addr", dmem.addr, 32'd0);
      check("rst_wdata", dmem.wdata, 32'd0);
      check("rst_rd", ReadDataM, 32'd0);
      check("rst_buserr", 32'(BusErrM), 32'd0);
      check("rst_mis", 32'(MisalignM), 32'd0);
      check("rst_stall", 32'(StallM), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      e_valid = 1;
      e_stall = 0; e_req = 0; e_err = 0; e_mis = 0; e_rd = '0;
      idle_cycle();

      // LW 0x100, ack on first BUSY cycle
      clr_counts();
      do_txn(1, 0, F3_LW, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
      idle_cycle();
      check("lw_model", m_rd, 32'hDEAD_BEEF);
      check("lw_rd", ReadDataM, 32'hDEAD_BEEF);
      check("lw_stall_cycles", 32'(stall_cnt), 32'd2);
      check("lw_req_cycles", 32'(req_cnt), 32'd1);

      // LB / LBU 0x103
      do_txn(1, 0, F3_LB, 32'h103, 32'h0, 1, 32'h80FF_0000);
      idle_cycle();
      check("lb_model", m_rd, 32'hFFFF_FF80);
      check("lb_rd", ReadDataM, 32'hFFFF_FF80);
      do_txn(1, 0, F3_LBU, 32'h103, 32'h0, 2, 32'h80FF_0000);
      idle_cycle();
      check("lbu_rd", ReadDataM, 32'h0000_0080);

      // SH 0x102, ReadDataM must keep the LBU result
      do_txn(0, 1, F3_SH, 32'h102, 32'h1234_ABCD, 0, 32'h0);
      idle_cycle();
      check("sh_wstrb", 32'(seen_wstrb), 32'hC);
      check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
      check("sh_we", 32'(seen_we), 32'd1);
      check("sh_rd_hold", ReadDataM, 32'h0000_0080);

      // Ack on the last allowed cycle wins over the timeout
      clr_counts();
      do_txn(1, 0, F3_LW, 32'h204, 32'h0, MAX_WAIT - 1, 32'h1357_9BDF);
      idle_cycle();
      check("late_ack_err", 32'(err_cnt), 32'd0);
      check("late_ack_rd", ReadDataM, 32'h1357_9BDF);

      // Timeout
      clr_counts();
      do_txn(1, 0, F3_LW, 32'h300, 32'h0, 1000, 32'h0);
      idle_cycle();
      check("tmo_err_pulses", 32'(err_cnt), 32'd1);
      check("tmo_req_cycles", 32'(req_cnt), 32'(MAX_WAIT));
      check("tmo_rd", ReadDataM, 32'd0);

`ifdef MISALIGN_TRAP_EN
      do_txn(1, 0, F3_LW, 32'h100, 32'h0, 0, 32'h5555_AAAA);
      clr_counts();
      do_txn(1, 0, F3_LW, 32'h101, 32'h0, 0, 32'h0);
      idle_cycle();
      check("mis_pulses", 32'(mis_cnt), 32'd1);
      check("mis_stall_cycles", 32'(stall_cnt), 32'd1);
      check("mis_req_cycles", 32'(req_cnt), 32'd0);
      check("mis_rd", ReadDataM, 32'd0);
`endif

      // Reset in BUSY, then a late ack
      do_txn(1, 0, F3_LW, 32'h400, 32'h0, 0, 32'hCAFE_F00D);
      @(posedge clk); #1;
      MemReadM = 1; MemWriteM = 0; funct3M = F3_LW; ALUResultM = 32'h500; dmem.ack = 0;
      e_stall = 1; e_req = 0; e_err = 0; e_rd = m_rd;
      e_addr = 32'h500; e_we = 0; e_wstrb = 4'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         e_req = 1;
      end
      @(negedge clk); #2;
      e_valid  = 0;
      reset    = 1'b1;
      MemReadM = 1'b0;
      #1;
      check("rst_busy_req", 32'(dmem.req), 32'd0);
      check("rst_busy_rd", ReadDataM, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      dmem.ack = 1'b1; dmem.rdata = 32'h7777_7777;
      m_rd = '0;
      e_valid = 1; e_stall = 0; e_req = 0; e_err = 0; e_mis = 0; e_rd = m_rd;
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      @(posedge clk); #1;
      check("late_ack_ignored", ReadDataM, 32'd0);
      check("late_ack_idle", 32'(StallM), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic        rd, wr;
         logic [2:0]  f3;
         int          dly;
         rd  = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         dly = int'($urandom_range(0, 5));
         if (rd && $urandom_range(0, 9) == 0) dly = int'($urandom_range(MAX_WAIT - 1, 40));
         if (rd || wr) do_txn(rd, wr, f3, $urandom, $urandom, dly, $urandom);
         if ($urandom_range(0, 2) == 0 || !(rd || wr)) idle_cycle();
      end
      idle_cycle();
      idle_cycle();
      e_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
